// File: rtl/uart_rx_bit_timer_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
//   Shared definitions for the UART RX bit timer.
//   - state_t     : timer state encoding (IDLE / RUN / DONE)
//   - MIN_PRESC   : smallest oversampling ratio the timer will run at
//   - DEF_*       : configuration register values after reset
//   - frame_bits(): total bits in a frame (start + data + parity + stop)
// ---------------------------------------------------------------------------
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int         MIN_PRESC = 4;
    localparam int         DEF_PRESC = 8;
    localparam logic [1:0] DEF_LEN   = 2'b11;   // 8 data bits
    localparam logic       DEF_PAR   = 1'b0;
    localparam logic       DEF_STOP2 = 1'b0;

    // start(1) + data(5..8) + parity(0/1) + stop(1/2): 7..12 bits
    function automatic logic [3:0] frame_bits(input logic [1:0] len,
                                              input logic       par,
                                              input logic       stop2);
        return 4'd7 + {2'b00, len} + {3'b000, par} + {3'b000, stop2};
    endfunction

endpackage

// File: rtl/uart_rx_bit_timer_if.sv
// ---------------------------------------------------------------------------
// uart_rx_bit_timer_if
//   Control / timing bundle between the RX FSM (master) and the bit timer
//   (slave).
//   master -> slave : enable, restart, Prescale, data_len, par_en, stop2
//   slave -> master : edge_cnt, bit_cnt, sample_stb, sample_idx,
//                     bit_end, frame_end, busy
// ---------------------------------------------------------------------------
interface uart_rx_bit_timer_if #(
    parameter int PRESC_W = 6,
    parameter int EDGE_W  = 6,
    parameter int BIT_W   = 4
);
    logic               enable;
    logic               restart;
    logic [PRESC_W-1:0] Prescale;
    logic [1:0]         data_len;
    logic               par_en;
    logic               stop2;

    logic [EDGE_W-1:0]  edge_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               sample_stb;
    logic [1:0]         sample_idx;
    logic               bit_end;
    logic               frame_end;
    logic               busy;

    modport master (
        output enable, restart, Prescale, data_len, par_en, stop2,
        input  edge_cnt, bit_cnt, sample_stb, sample_idx, bit_end, frame_end, busy
    );

    modport slave (
        input  enable, restart, Prescale, data_len, par_en, stop2,
        output edge_cnt, bit_cnt, sample_stb, sample_idx, bit_end, frame_end, busy
    );
endinterface

// File: rtl/uart_rx_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_rx_bit_timer
//   Oversampling edge/bit timer for the UART RX path. Counts oversampling
//   edges within a bit and bits within a frame, and decodes three mid-bit
//   sample strobes plus bit-end / frame-end pulses. The frame format and
//   prescale are latched when a frame starts and stay fixed for that frame.
// Ports
//   CLK  : RX oversampling clock
//   RST  : asynchronous, active-low reset
//   bus  : slave side of uart_rx_bit_timer_if (controls in, timing out)
// ---------------------------------------------------------------------------
module uart_rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = 6,
    parameter int EDGE_W  = 6,
    parameter int BIT_W   = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_rx_bit_timer_if.slave    bus
);

    localparam int CW = (EDGE_W > PRESC_W) ? EDGE_W : PRESC_W;

    state_t             r_state,    w_state_nxt;
    logic [EDGE_W-1:0]  r_edge_cnt, w_edge_nxt;
    logic [BIT_W-1:0]   r_bit_cnt,  w_bit_nxt;
    logic [PRESC_W-1:0] r_presc_q,  w_presc_nxt;
    logic [1:0]         r_len_q,    w_len_nxt;
    logic               r_par_q,    w_par_nxt;
    logic               r_stop2_q,  w_stop2_nxt;

    logic [PRESC_W-1:0] w_presc_in;
    logic [CW-1:0]      w_edge_x;
    logic [CW-1:0]      w_presc_m1;
    logic [CW-1:0]      w_mid;
    logic [CW-1:0]      w_lo;
    logic [CW-1:0]      w_hi;
    logic [BIT_W-1:0]   w_last_bit_idx;
    logic               w_run;
    logic               w_last_edge;
    logic               w_last_bit;
    logic               w_stb;

    // Prescale below the minimum is clamped up rather than rejected
    assign w_presc_in = (bus.Prescale < PRESC_W'(MIN_PRESC)) ? PRESC_W'(MIN_PRESC)
                                                             : bus.Prescale;

    assign w_run          = (r_state == ST_RUN);
    assign w_edge_x       = CW'(r_edge_cnt);
    assign w_presc_m1     = CW'(r_presc_q) - CW'(1);
    assign w_last_edge    = (w_edge_x == w_presc_m1);
    assign w_last_bit_idx = BIT_W'(frame_bits(r_len_q, r_par_q, r_stop2_q) - 4'd1);
    assign w_last_bit     = (r_bit_cnt == w_last_bit_idx);

    // presc_q >= 4 so mid >= 2: the sample window never underflows
    assign w_mid = CW'(r_presc_q >> 1);
    assign w_lo  = w_mid - CW'(1);
    assign w_hi  = w_mid + CW'(1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= ST_IDLE;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_presc_q  <= PRESC_W'(DEF_PRESC);
            r_len_q    <= DEF_LEN;
            r_par_q    <= DEF_PAR;
            r_stop2_q  <= DEF_STOP2;
        end else begin
            r_state    <= w_state_nxt;
            r_edge_cnt <= w_edge_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_presc_q  <= w_presc_nxt;
            r_len_q    <= w_len_nxt;
            r_par_q    <= w_par_nxt;
            r_stop2_q  <= w_stop2_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_edge_nxt  = r_edge_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_presc_nxt = r_presc_q;
        w_len_nxt   = r_len_q;
        w_par_nxt   = r_par_q;
        w_stop2_nxt = r_stop2_q;

        if (!bus.enable) begin
            w_state_nxt = ST_IDLE;
            w_edge_nxt  = '0;
            w_bit_nxt   = '0;
        end else if (r_state == ST_IDLE || bus.restart) begin
            // Frame start or re-sync: both re-latch the format
            w_state_nxt = ST_RUN;
            w_edge_nxt  = '0;
            w_bit_nxt   = '0;
            w_presc_nxt = w_presc_in;
            w_len_nxt   = bus.data_len;
            w_par_nxt   = bus.par_en;
            w_stop2_nxt = bus.stop2;
        end else if (r_state == ST_RUN) begin
            if (w_last_edge) begin
                w_edge_nxt = '0;
                if (w_last_bit) begin
                    w_bit_nxt   = '0;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_bit_nxt = r_bit_cnt + BIT_W'(1);
                end
            end else begin
                w_edge_nxt = r_edge_cnt + EDGE_W'(1);
            end
        end else begin
            // DONE waits for enable to drop; counters stay at zero
            w_edge_nxt = '0;
            w_bit_nxt  = '0;
        end
    end

    assign w_stb = w_run && (w_edge_x >= w_lo) && (w_edge_x <= w_hi);

    assign bus.edge_cnt   = r_edge_cnt;
    assign bus.bit_cnt    = r_bit_cnt;
    assign bus.busy       = w_run;
    assign bus.bit_end    = w_run & w_last_edge;
    assign bus.frame_end  = w_run & w_last_edge & w_last_bit;
    assign bus.sample_stb = w_stb;
    assign bus.sample_idx = w_stb ? 2'(w_edge_x - w_lo) : 2'd0;

endmodule
